// File: rtl/lcd_pkg.sv
// Shared types, command codes and default timing for the HD44780 bus engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_POLL_SETUP,
    ST_POLL_EN,
    ST_POLL_CHK
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Default timing in 50 MHz clock cycles.
  localparam int unsigned DEF_SETUP_CYC     = 3;
  localparam int unsigned DEF_EN_HIGH_CYC   = 12;
  localparam int unsigned DEF_HOLD_CYC      = 2;
  localparam int unsigned DEF_EXEC_CYC      = 2000;
  localparam int unsigned DEF_LONG_EXEC_CYC = 82000;
  localparam int unsigned DEF_POLL_LIMIT    = 100000;

  // Counter load value for a phase of n cycles; a zero-length phase still takes one cycle.
  function automatic int unsigned cyc_load(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear and both home encodings need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d == LCD_CMD_CLEAR) || (d == LCD_CMD_HOME) ||
                   (d == (LCD_CMD_HOME | LCD_CMD_CLEAR)));
  endfunction

endpackage

// File: rtl/lcd_bus_engine_if.sv
// Producer-side command handshake for the LCD bus engine.
interface lcd_bus_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that parks at zero; zero marks the last cycle of a phase.
module lcd_delay_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_engine.sv
// HD44780 character-LCD bus engine: one byte per handshake, then
// setup / EN pulse / hold / execution wait on the LCD pins.
// Optional macro LCD_BUSY_POLL_EN replaces the fixed execution wait with
// busy-flag polling bounded by POLL_LIMIT.
module lcd_bus_engine
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned EN_HIGH_CYC   = DEF_EN_HIGH_CYC,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned EXEC_CYC      = DEF_EXEC_CYC,
  parameter int unsigned LONG_EXEC_CYC = DEF_LONG_EXEC_CYC,
  parameter int unsigned POLL_LIMIT    = DEF_POLL_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  lcd_bus_engine_if.slave     cmd,
  output logic [7:0]          lcd_data,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_en,
  output logic                lcd_data_oe,
  input  logic [7:0]          lcd_data_in,
  output logic                busy,
  output logic                timeout
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, EN_HIGH_CYC),
                                                max_u(HOLD_CYC, EXEC_CYC)),
                                          max_u(LONG_EXEC_CYC, POLL_LIMIT));
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(cyc_load(SETUP_CYC));
  localparam logic [CW-1:0] LD_EN    = CW'(cyc_load(EN_HIGH_CYC));
  localparam logic [CW-1:0] LD_HOLD  = CW'(cyc_load(HOLD_CYC));
  localparam logic [CW-1:0] LD_EXEC  = CW'(cyc_load(EXEC_CYC));
  localparam logic [CW-1:0] LD_LONG  = CW'(cyc_load(LONG_EXEC_CYC));

  lcd_state_e    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;

`ifdef LCD_BUSY_POLL_EN
  localparam int unsigned PCW = $clog2(POLL_LIMIT + 1) + 1;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           flag_q, flag_d;
  logic           timeout_q, timeout_d;
  logic           unused_data_in;
  assign unused_data_in = ^lcd_data_in[6:0];
`else
  logic           unused_data_in;
  assign unused_data_in = ^lcd_data_in;
`endif

  lcd_delay_cnt #(.WIDTH(CW)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state, byte latch, counter loads and pin decode.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
`ifdef LCD_BUSY_POLL_EN
    poll_cnt_d  = poll_cnt_q;
    flag_d      = flag_q;
    timeout_d   = timeout_q;
`endif

    cmd.cmd_ready = (state_q == ST_IDLE) && !reset;
    busy          = (state_q != ST_IDLE);
    lcd_data      = data_q;
    lcd_rs        = rs_q;
    lcd_rw        = 1'b0;
    lcd_en        = (state_q == ST_PULSE);
    lcd_data_oe   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          data_d   = cmd.cmd_data;
          rs_d     = cmd.cmd_rs;
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d  = ST_PULSE;
          cnt_load = 1'b1;
          cnt_val  = LD_EN;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
`ifdef LCD_BUSY_POLL_EN
          state_d    = ST_POLL_SETUP;
          cnt_val    = LD_SETUP;
          poll_cnt_d = '0;
`else
          state_d    = ST_EXEC;
          cnt_val    = is_long_cmd(rs_q, data_q) ? LD_LONG : LD_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
`ifdef LCD_BUSY_POLL_EN
      ST_POLL_SETUP, ST_POLL_EN, ST_POLL_CHK: begin
        lcd_rw      = 1'b1;
        lcd_rs      = 1'b0;
        lcd_data_oe = 1'b0;
        lcd_en      = (state_q == ST_POLL_EN);
        if (poll_cnt_q >= PCW'(POLL_LIMIT)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          if (cnt_zero) begin
            if (state_q == ST_POLL_SETUP) begin
              state_d  = ST_POLL_EN;
              cnt_load = 1'b1;
              cnt_val  = LD_EN;
            end else if (state_q == ST_POLL_EN) begin
              // Busy flag is captured on the final EN-high cycle.
              flag_d   = lcd_data_in[7];
              state_d  = ST_POLL_CHK;
              cnt_load = 1'b1;
              cnt_val  = LD_HOLD;
            end else if (flag_q) begin
              state_d  = ST_POLL_EN;
              cnt_load = 1'b1;
              cnt_val  = LD_EN;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched byte registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      rs_q       <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_cnt_q <= '0;
      flag_q     <= 1'b0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
`ifdef LCD_BUSY_POLL_EN
      poll_cnt_q <= poll_cnt_d;
      flag_q     <= flag_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

`ifdef LCD_BUSY_POLL_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
